// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the ID/EX stage.
// Default widths, ALU-op width, EX control bundle and the bubble constant.
package pipe_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;

    // Control bundle carried from decode into EX.
    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic [ALUOP_W-1:0] aluop;
    } ex_ctrl_t;

    // A bubble is an all-zero control bundle: no write, no memory access.
    localparam ex_ctrl_t BUBBLE_CTRL = '0;

    // Where an EX operand is taken from.
    typedef enum logic {
        SRC_REGFILE = 1'b0,
        SRC_MEM_FWD = 1'b1
    } opnd_src_e;

endpackage

// File: rtl/id_hazard_detect.sv
// Hazard compare and stall generation for the decode slot.
// Optional feature: ID_EX_FORWARD_EN enables forwarding of non-load MEM-stage
// results; without it every MEM-stage match stalls instead.
module id_hazard_detect #(
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              flush,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_valid,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    output logic              stall_o,
    output logic              fwd_a,
    output logic              fwd_b
);
    import pipe_pkg::*;

    logic w_ex_hit_a;
    logic w_ex_hit_b;
    logic w_mem_hit_a;
    logic w_mem_hit_b;
    logic w_mem_stall;

    // A source matches a producer only if it is really read, the producer
    // writes, and the target is not $0 (which is hard-wired to zero).
    function automatic logic src_match(
        input logic              use_src,
        input logic [REG_AW-1:0] src,
        input logic              regwrite,
        input logic [REG_AW-1:0] wreg
    );
        return use_src && regwrite && (src == wreg) && (wreg != '0);
    endfunction

    // Compare both sources against the EX and MEM producers.
    always_comb begin
        w_ex_hit_a  = src_match(id_use_rs, id_rs, ex_valid && ex_regwrite, ex_wreg);
        w_ex_hit_b  = src_match(id_use_rt, id_rt, ex_valid && ex_regwrite, ex_wreg);
        w_mem_hit_a = src_match(id_use_rs, id_rs, mem_regwrite, mem_wreg);
        w_mem_hit_b = src_match(id_use_rt, id_rt, mem_regwrite, mem_wreg);
    end

    // Decide stall versus forward for MEM-stage matches.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_mem_stall = 1'b0;
        fwd_a       = SRC_REGFILE;
        fwd_b       = SRC_REGFILE;
`ifdef ID_EX_FORWARD_EN
        // Load data is not ready until the end of MEM: stall; ALU results forward.
        w_mem_stall = (w_mem_hit_a || w_mem_hit_b) && mem_memread;
        fwd_a       = w_mem_hit_a && !mem_memread;
        fwd_b       = w_mem_hit_b && !mem_memread;
`else
        // No bypass path: wait until the producer reaches WB.
        w_mem_stall = w_mem_hit_a || w_mem_hit_b;
`endif
    end

    // Flush wins over stall; reset forces the request low.
    always_comb begin
        stall_o = rst_n && id_valid && !flush &&
                  (w_ex_hit_a || w_ex_hit_b || w_mem_stall);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard stall and optional MEM-stage forwarding.
// Optional feature: ID_EX_FORWARD_EN selects mem_data into the operands when a
// non-load MEM-stage producer matches; otherwise operands come from the
// register file only.
module id_ex_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         id_valid,
    input  logic [REG_AW-1:0]            id_rs,
    input  logic [REG_AW-1:0]            id_rt,
    input  logic [REG_AW-1:0]            id_wreg,
    input  logic                         id_use_rs,
    input  logic                         id_use_rt,
    input  logic [DATA_W-1:0]            id_rdata1,
    input  logic [DATA_W-1:0]            id_rdata2,
    input  logic [DATA_W-1:0]            id_imm,
    input  logic                         id_regwrite,
    input  logic                         id_memread,
    input  logic                         id_memwrite,
    input  logic [pipe_pkg::ALUOP_W-1:0] id_aluop,
    input  logic [REG_AW-1:0]            mem_wreg,
    input  logic                         mem_regwrite,
    input  logic                         mem_memread,
    input  logic [DATA_W-1:0]            mem_data,
    input  logic                         flush,
    output logic                         stall_o,
    output logic                         ex_valid,
    output logic                         ex_regwrite,
    output logic                         ex_memread,
    output logic                         ex_memwrite,
    output logic [pipe_pkg::ALUOP_W-1:0] ex_aluop,
    output logic [REG_AW-1:0]            ex_wreg,
    output logic [DATA_W-1:0]            ex_opa,
    output logic [DATA_W-1:0]            ex_opb,
    output logic [DATA_W-1:0]            ex_imm
);
    import pipe_pkg::*;

    ex_ctrl_t            r_ctrl;
    logic [REG_AW-1:0]   r_wreg;
    logic [DATA_W-1:0]   r_opa;
    logic [DATA_W-1:0]   r_opb;
    logic [DATA_W-1:0]   r_imm;

    logic                w_stall;
    logic                w_fwd_a;
    logic                w_fwd_b;
    logic                w_load_bubble;
    ex_ctrl_t            w_id_ctrl;
    logic [DATA_W-1:0]   w_opa;
    logic [DATA_W-1:0]   w_opb;

    id_hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .flush        (flush),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_valid     (r_ctrl.valid),
        .ex_regwrite  (r_ctrl.regwrite),
        .ex_wreg      (r_wreg),
        .mem_wreg     (mem_wreg),
        .mem_regwrite (mem_regwrite),
        .mem_memread  (mem_memread),
        .stall_o      (w_stall),
        .fwd_a        (w_fwd_a),
        .fwd_b        (w_fwd_b)
    );

    // Bundle decode controls and decide whether this edge loads a bubble.
    always_comb begin
        w_id_ctrl.valid    = id_valid;
        w_id_ctrl.regwrite = id_regwrite;
        w_id_ctrl.memread  = id_memread;
        w_id_ctrl.memwrite = id_memwrite;
        w_id_ctrl.aluop    = id_aluop;
        w_load_bubble      = w_stall || flush;
    end

`ifdef ID_EX_FORWARD_EN
    // Operand muxes: bypass the MEM-stage ALU result when it is newer.
    always_comb begin
        w_opa = (w_fwd_a == SRC_MEM_FWD) ? mem_data : id_rdata1;
        w_opb = (w_fwd_b == SRC_MEM_FWD) ? mem_data : id_rdata2;
    end
`else
    logic w_unused_fwd;

    // Operands come straight from the register file; the bypass inputs are idle.
    always_comb begin
        w_opa        = id_rdata1;
        w_opb        = id_rdata2;
        w_unused_fwd = ^{w_fwd_a, w_fwd_b, mem_data};
    end
`endif

    // ID/EX register: bubble on stall/flush, else capture the decode slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_ctrl <= BUBBLE_CTRL;
            r_wreg <= '0;
            r_opa  <= '0;
            r_opb  <= '0;
            r_imm  <= '0;
        end else if (w_load_bubble) begin
            r_ctrl <= BUBBLE_CTRL;
            r_wreg <= '0;
            r_opa  <= '0;
            r_opb  <= '0;
            r_imm  <= '0;
        end else begin
            r_ctrl <= w_id_ctrl;
            r_wreg <= id_wreg;
            r_opa  <= w_opa;
            r_opb  <= w_opb;
            r_imm  <= id_imm;
        end
    end

    // Drive the EX-side outputs from the pipeline register.
    always_comb begin
        stall_o     = w_stall;
        ex_valid    = r_ctrl.valid;
        ex_regwrite = r_ctrl.regwrite;
        ex_memread  = r_ctrl.memread;
        ex_memwrite = r_ctrl.memwrite;
        ex_aluop    = r_ctrl.aluop;
        ex_wreg     = r_wreg;
        ex_opa      = r_opa;
        ex_opb      = r_opb;
        ex_imm      = r_imm;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage with an expected-result queue.
// Expectations follow the build: ID_EX_FORWARD_EN selects forward-vs-stall results.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_wreg;
    logic        id_use_rs, id_use_rt;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic        id_regwrite, id_memread, id_memwrite;
    logic [3:0]  id_aluop;
    logic [4:0]  mem_wreg;
    logic        mem_regwrite, mem_memread;
    logic [31:0] mem_data;
    logic        flush;
    logic        stall_o;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic [3:0]  ex_aluop;
    logic [4:0]  ex_wreg;
    logic [31:0] ex_opa, ex_opb, ex_imm;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, wreg;
        logic        use_rs, use_rt;
        logic [31:0] rdata1, rdata2, imm;
        logic        regwrite, memread, memwrite;
        logic [3:0]  aluop;
    } instr_t;

    typedef struct {
        logic [7:0]  ctl;
        logic [4:0]  wreg;
        logic [31:0] opa, opb, imm;
    } exp_t;

    exp_t sb[$];

    id_ex_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_wreg      (id_wreg),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_rdata1    (id_rdata1),
        .id_rdata2    (id_rdata2),
        .id_imm       (id_imm),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .id_memwrite  (id_memwrite),
        .id_aluop     (id_aluop),
        .mem_wreg     (mem_wreg),
        .mem_regwrite (mem_regwrite),
        .mem_memread  (mem_memread),
        .mem_data     (mem_data),
        .flush        (flush),
        .stall_o      (stall_o),
        .ex_valid     (ex_valid),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_memwrite  (ex_memwrite),
        .ex_aluop     (ex_aluop),
        .ex_wreg      (ex_wreg),
        .ex_opa       (ex_opa),
        .ex_opb       (ex_opb),
        .ex_imm       (ex_imm)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(input logic [4:0] rs, input logic use_rs,
                                  input logic [4:0] rt, input logic use_rt,
                                  input logic [4:0] wreg, input logic rw,
                                  input logic mr, input logic [3:0] op,
                                  input logic [31:0] d1, input logic [31:0] d2,
                                  input logic [31:0] imm);
        instr_t t;
        t.valid = 1'b1; t.rs = rs; t.rt = rt; t.wreg = wreg;
        t.use_rs = use_rs; t.use_rt = use_rt;
        t.rdata1 = d1; t.rdata2 = d2; t.imm = imm;
        t.regwrite = rw; t.memread = mr; t.memwrite = 1'b0; t.aluop = op;
        return t;
    endfunction

    task automatic drive_id(input instr_t t);
        id_valid = t.valid; id_rs = t.rs; id_rt = t.rt; id_wreg = t.wreg;
        id_use_rs = t.use_rs; id_use_rt = t.use_rt;
        id_rdata1 = t.rdata1; id_rdata2 = t.rdata2; id_imm = t.imm;
        id_regwrite = t.regwrite; id_memread = t.memread;
        id_memwrite = t.memwrite; id_aluop = t.aluop;
    endtask

    task automatic set_mem(input logic [4:0] w, input logic rw, input logic mr, input logic [31:0] d);
        mem_wreg = w; mem_regwrite = rw; mem_memread = mr; mem_data = d;
    endtask

    // One pipeline cycle: drive at negedge, check stall, push expectation,
    // then pop and compare the registered EX outputs after the rising edge.
    task automatic step(input string tag, input instr_t t, input logic fl,
                        input logic exp_stall, input logic [31:0] exp_opa,
                        input logic [31:0] exp_opb);
        exp_t e;
        @(negedge clk);
        drive_id(t);
        flush = fl;
        #1;
        chk({tag, ".stall"}, {95'd0, stall_o}, {95'd0, exp_stall});
        if (exp_stall || fl) begin
            e.ctl = 8'd0; e.wreg = 5'd0; e.opa = 32'd0; e.opb = 32'd0; e.imm = 32'd0;
        end else begin
            e.ctl  = {t.valid, t.regwrite, t.memread, t.memwrite, t.aluop};
            e.wreg = t.wreg; e.opa = exp_opa; e.opb = exp_opb; e.imm = t.imm;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".ctl"}, {83'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_aluop, ex_wreg},
            {83'd0, e.ctl, e.wreg});
        if (e.ctl[7]) begin
            chk({tag, ".opa"}, {64'd0, ex_opa}, {64'd0, e.opa});
            chk({tag, ".opb"}, {64'd0, ex_opb}, {64'd0, e.opb});
            chk({tag, ".imm"}, {64'd0, ex_imm}, {64'd0, e.imm});
        end
        flush = 1'b0;
    endtask

    initial begin
        instr_t nop;
        instr_t sub3, or4, rd0, rd9;
        nop = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
        nop.valid = 1'b0;

        // Reset with a live MEM load match on the inputs: no stall, outputs zero.
        rst_n = 1'b0;
        flush = 1'b0;
        drive_id(mk(5'd4, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 4'd3, 32'h1, 32'h2, 32'h3));
        set_mem(5'd4, 1'b1, 1'b1, 32'h1234);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall", {95'd0, stall_o}, 96'd0);
        chk("reset.ctl", {83'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_aluop, ex_wreg}, 96'd0);
        chk("reset.ops", {ex_opa, ex_opb, ex_imm}, 96'd0);
        @(negedge clk);
        drive_id(nop);
        set_mem(5'd0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;

        // add $3 in EX, then sub reading $3.
        step("add3", mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 4'd2, 32'd11, 32'd22, 32'd5),
             1'b0, 1'b0, 32'd11, 32'd22);
        sub3 = mk(5'd3, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 4'd6, 32'd33, 32'd44, 32'd0);
        step("sub3_ex", sub3, 1'b0, 1'b1, 32'd0, 32'd0);
        set_mem(5'd3, 1'b1, 1'b0, 32'hDEAD_0003);
`ifdef ID_EX_FORWARD_EN
        step("sub3_fwd", sub3, 1'b0, 1'b0, 32'hDEAD_0003, 32'd44);
        set_mem(5'd0, 1'b0, 1'b0, 32'd0);
`else
        step("sub3_mem", sub3, 1'b0, 1'b1, 32'd0, 32'd0);
        set_mem(5'd0, 1'b0, 1'b0, 32'd0);
        step("sub3_wb", sub3, 1'b0, 1'b0, 32'd33, 32'd44);
`endif

        // lw $4, then or reading $4: stall through EX and MEM, then register file.
        step("lw4", mk(5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 4'd0, 32'd100, 32'd0, 32'd8),
             1'b0, 1'b0, 32'd100, 32'd0);
        or4 = mk(5'd4, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 4'd5, 32'h44, 32'd22, 32'd0);
        step("or4_ex", or4, 1'b0, 1'b1, 32'd0, 32'd0);
        set_mem(5'd4, 1'b1, 1'b1, 32'hBEEF);
        step("or4_mem", or4, 1'b0, 1'b1, 32'd0, 32'd0);
        set_mem(5'd0, 1'b0, 1'b0, 32'd0);
        step("or4_wb", or4, 1'b0, 1'b0, 32'h44, 32'd22);

        // Writes to $0 never stall or forward.
        step("wr0", mk(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 4'd1, 32'd1, 32'd0, 32'd9),
             1'b0, 1'b0, 32'd1, 32'd0);
        set_mem(5'd0, 1'b1, 1'b0, 32'hBAD);
        rd0 = mk(5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 4'd2, 32'd0, 32'd0, 32'd0);
        step("rd0", rd0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_mem(5'd0, 1'b0, 1'b0, 32'd0);

        // Stall condition together with flush: no stall, bubble loaded.
        step("prod9", mk(5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 4'd2, 32'd2, 32'd0, 32'd0),
             1'b0, 1'b0, 32'd2, 32'd0);
        rd9 = mk(5'd9, 1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0, 4'd3, 32'd7, 32'd8, 32'd0);
        step("flush", rd9, 1'b1, 1'b0, 32'd0, 32'd0);

        // Unused source field matching a MEM load: no stall.
        set_mem(5'd9, 1'b1, 1'b1, 32'h999);
        step("nouse", mk(5'd9, 1'b0, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 4'd4, 32'h77, 32'h88, 32'd1),
             1'b0, 1'b0, 32'h77, 32'h88);

        // rs == rt, both matching a MEM-stage ALU producer.
        set_mem(5'd10, 1'b1, 1'b0, 32'hCAFE_0010);
`ifdef ID_EX_FORWARD_EN
        step("same_fwd", mk(5'd10, 1'b1, 5'd10, 1'b1, 5'd12, 1'b1, 1'b0, 4'd2, 32'd1, 32'd2, 32'd0),
             1'b0, 1'b0, 32'hCAFE_0010, 32'hCAFE_0010);
        set_mem(5'd0, 1'b0, 1'b0, 32'd0);
`else
        step("same_stall", mk(5'd10, 1'b1, 5'd10, 1'b1, 5'd12, 1'b1, 1'b0, 4'd2, 32'd1, 32'd2, 32'd0),
             1'b0, 1'b1, 32'd0, 32'd0);
        set_mem(5'd0, 1'b0, 1'b0, 32'd0);
        step("same_wb", mk(5'd10, 1'b1, 5'd10, 1'b1, 5'd12, 1'b1, 1'b0, 4'd2, 32'd1, 32'd2, 32'd0),
             1'b0, 1'b0, 32'd1, 32'd2);
`endif

        // Reset asserted mid-stall.
        step("prod13", mk(5'd1, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 4'd7, 32'd5, 32'd0, 32'd6),
             1'b0, 1'b0, 32'd5, 32'd0);
        @(negedge clk);
        drive_id(mk(5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 4'd2, 32'h31, 32'd0, 32'h2));
        #1;
        chk("midrst.pre_stall", {95'd0, stall_o}, 96'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst.stall", {95'd0, stall_o}, 96'd0);
        chk("midrst.ctl", {83'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_aluop, ex_wreg}, 96'd0);
        chk("midrst.ops", {ex_opa, ex_opb, ex_imm}, 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", mk(5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 4'd2, 32'h31, 32'd0, 32'h2),
             1'b0, 1'b0, 32'h31, 32'd0);

        // Idle slot passes as an invalid entry.
        step("idle", nop, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the operand/immediate width.
REQ-002 Parameter REG_AW, default 5, SHALL set the register-address width.
REQ-003 clk  in  1  pipeline clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_valid  in  1  decode slot holds a real instruction.
REQ-006 id_rs, id_rt, id_wreg  in  REG_AW each  source A, source B, destination.
REQ-007 id_use_rs, id_use_rt  in  1 each  instruction actually reads that source.
REQ-008 id_rdata1, id_rdata2  in  DATA_W each  register-file read data.
REQ-009 id_imm  in  DATA_W  sign-extended immediate.
REQ-010 id_regwrite, id_memread, id_memwrite  in  1 each; id_aluop  in  4  decoded controls.
REQ-011 mem_wreg  in  REG_AW; mem_regwrite, mem_memread  in  1; mem_data  in  DATA_W  EX/MEM producer.
REQ-012 flush  in  1  taken-branch squash of the decode slot.
REQ-013 stall_o  out  1  combinational hold request to PC and IF/ID.
REQ-014 ex_valid, ex_regwrite, ex_memread, ex_memwrite  out  1; ex_aluop  out  4; ex_wreg  out  REG_AW.
REQ-015 ex_opa, ex_opb, ex_imm  out  DATA_W  registered operands for EX.

Function
REQ-016 A "match" SHALL mean: source used, source equal to the producer's wreg, producer regwrite=1, and wreg != 0.
REQ-017 Register 0 SHALL never cause a stall or forward.
REQ-018 stall_o SHALL be 1 when id_valid=1 and flush=0 and the instruction matches the instruction now in EX (ex_valid=1).
REQ-019 stall_o SHALL also be 1 when id_valid=1 and flush=0 and the instruction matches the MEM-stage producer with mem_memread=1.
REQ-020 On a clock edge with stall_o=1 or flush=1, the block SHALL load a bubble: ex_valid, ex_regwrite, ex_memread, ex_memwrite=0; ex_aluop, ex_wreg=0.
REQ-021 Otherwise the block SHALL register the decode slot with one-cycle latency, ex_valid=id_valid.
REQ-022 A matching MEM-stage producer with mem_memread=0 SHALL forward mem_data into ex_opa/ex_opb in place of id_rdata1/id_rdata2.
REQ-023 A WB-stage RAW SHALL need no action, because the register file writes on the falling edge before the next rising edge samples.
REQ-024 flush SHALL override stall: flush=1 forces stall_o=0.
REQ-025 A stall SHALL persist each cycle until its condition clears; each stalled cycle inserts exactly one bubble.
REQ-026 id_rs==id_rt SHALL forward or stall both operands consistently.

Reset
REQ-027 While rst_n=0, all ex_* outputs SHALL be 0, asynchronously.
REQ-028 stall_o SHALL evaluate to 0 during reset.
REQ-029 The first rising edge after deassertion SHALL capture normally.

Configuration
REQ-030 With ID_EX_FORWARD_EN defined, REQ-022 SHALL be active.
REQ-031 Without ID_EX_FORWARD_EN, there SHALL be no mem_data path: any MEM-stage match SHALL stall regardless of mem_memread, and operands SHALL come only from id_rdata1/id_rdata2.

Structure
REQ-032 Package pipe_pkg SHALL hold DATA_W, REG_AW, the ALUOp width, and a bubble-control constant.
REQ-033 Hazard compare and stall logic SHALL live in sub-module id_hazard_detect; the register and forward muxes stay in id_ex_stage.

Verification
REQ-034 add $3 in EX, then sub reading $3 in ID -> stall_o=1 for one cycle, one bubble, then sub issues with ex_opa = mem_data.
REQ-035 lw $4 in MEM (mem_memread=1), then or reading $4 in ID -> stall_o=1 for one cycle, then operand = id_rdata (WB path).
REQ-036 EX writes $0, then ID reads $0 -> stall_o=0, ex_opa = id_rdata1.
REQ-037 stall condition and flush=1 on the same cycle -> stall_o=0, bubble loaded.
REQ-038 rst_n low mid-stall -> all ex_* outputs 0 immediately; the first instruction after release passes with latency 1.
REQ-039 ID_EX_FORWARD_EN undefined: MEM-stage ALU producer $5 with a reader of $5 in ID -> one stall cycle, no forward.
